mult_seq_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult_seq_dp.sv | 50 +++++
 rtl/mult_seq_ctrl.sv | 109 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
/*------------------------------------------------------------------------------
 * Module : mult_pkg
 * Shared types and constants for the sequential shift-and-add multiplier.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH = 4;

  // Counter must reach WIDTH, so it needs one state beyond WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_seq_dp.sv
/*------------------------------------------------------------------------------
 * Module : mult_seq_dp
 * Shift-and-add datapath: accumulator, shifting multiplicand/multiplier, adder.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module mult_seq_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] acc,
  output logic               mplier_zero
);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else if (load) begin
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, x};
      mplier_r <= y;
    end else if (step) begin
      acc_r    <= acc;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end
  end

  // acc includes this cycle's partial product, so the top can capture the
  // final product on the same edge that performs the last add.
  assign acc         = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
  assign mplier_zero = (mplier_r[WIDTH-1:1] == '0);

endmodule

`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
/*------------------------------------------------------------------------------
 * Module : mult_seq_ctrl
 * Sequential multiplier control: FSM, iteration counter, start/busy/done
 * handshake and result registers. Optional macro MULT_EARLY_TERM_EN ends the
 * run as soon as the remaining multiplier bits are all zero.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   res,
  output logic [2*WIDTH-1:0] prod,
  output logic               ovf
);

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               last_step;
  logic               mplier_zero;
  logic [2*WIDTH-1:0] acc;

  mult_seq_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .x           (x),
    .y           (y),
    .acc         (acc),
    .mplier_zero (mplier_zero)
  );

  assign last_step = (cnt == CNT_LAST) || (EARLY_TERM && mplier_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (step && last_step) begin
        prod <= acc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign res   = prod[WIDTH-1:0];
  assign ovf   = |prod[2*WIDTH-1:WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
/*------------------------------------------------------------------------------
 * Module : tb_mult_seq_ctrl
 * Self-checking bench for mult_seq_ctrl against a transaction-level model.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_mult_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         ready, busy, done, ovf;
  logic [W-1:0] res;
  logic [2*W-1:0] prod;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .res   (res),
    .prod  (prod),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL timeout_%s: got no event expected one at %0t", name, $time);
  endtask

  // Latency in cycles from the accepting edge to the cycle where done is sampled.
  function automatic int lat(input logic [W-1:0] yy);
`ifdef MULT_EARLY_TERM_EN
    int top = 0;
    for (int i = 0; i < W; i++) if (yy[i]) top = i + 1;
    if (top < 1) top = 1;
    return top + 1;
`else
    return W + 1;
`endif
  endfunction

  // Transaction model: t counts edges since acceptance; done at t == L-1.
  bit           m_active = 0;
  int           m_t = 0;
  int           m_L = 0;
  logic [2*W-1:0] m_pend = '0;
  logic [2*W-1:0] m_prod = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_t      = 0;
      m_prod   = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_t      = 0;
        m_L      = lat(y);
        m_pend   = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      end
    end else begin
      m_t++;
      if (m_t == m_L - 1) m_prod = m_pend;
      else if (m_t >= m_L) m_active = 0;
    end
  end

  always @(negedge clk) begin
    check("ready", ready, !m_active);
    check("busy",  busy,  m_active && (m_t < m_L - 1));
    check("done",  done,  m_active && (m_t == m_L - 1));
    check("prod",  prod,  m_prod);
    check("res",   res,   m_prod[W-1:0]);
    check("ovf",   ovf,   |m_prod[2*W-1:W]);
    if (done) done_seen++;
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!ready) timeout("ready");
  endtask

  // Issues one multiply; returns at the negedge where done is high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int latency, output logic rdy_after);
    bit got = 0;
    wait_ready();
    x = a; y = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    latency = 0;
    rdy_after = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      latency++;
      if (latency == 1) rdy_after = ready;
      if (done) got = 1;
    end
    if (!got) timeout("done");
  endtask

  int   l;
  logic r;
  int   d0;
  int   gap;
  bit   got;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 1'b1);
    check("reset_prod",  prod,  8'h00);
    check("reset_done",  done,  1'b0);
    #2 rst = 1'b0;

    run_op(4'd3, 4'd2, l, r);
    check("t1_ready_drop", r, 1'b0);
    check("t1_prod", prod, 8'h06);
    check("t1_res",  res,  4'h6);
    check("t1_ovf",  ovf,  1'b0);
`ifndef MULT_EARLY_TERM_EN
    check("t1_latency", l, 5);
`endif
    @(negedge clk);
    check("t1_ready_back", ready, 1'b1);

    run_op(4'd15, 4'd15, l, r);
    check("t2_prod", prod, 8'hE1);
    check("t2_res",  res,  4'h1);
    check("t2_ovf",  ovf,  1'b1);
    repeat (10) begin
      @(negedge clk);
      check("t2_hold", {ovf, res, prod}, {1'b1, 4'h1, 8'hE1});
    end

    // start during RUN must be ignored
    wait_ready();
    d0 = done_seen;
    x = 4'd5; y = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 4'd7; y = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_prod", prod, 8'd15);
    check("t3_single_done", done_seen - d0, 1);
    check("t3_ready", ready, 1'b1);

    // reset two cycles into RUN discards the result
    wait_ready();
    x = 4'd9; y = 4'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    d0 = done_seen;
    #2 rst = 1'b1;
    #1;
    check("t4_prod_zero", prod, 8'h00);
    check("t4_busy", busy, 1'b0);
    check("t4_ready", ready, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_no_done", done_seen - d0, 0);
    run_op(4'd2, 4'd4, l, r);
    check("t4_next_prod", prod, 8'd8);

    // back-to-back with start held high
    wait_ready();
    x = 4'd4; y = 4'd3; start = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) timeout("b2b_first");
    check("t5_prod0", prod, 8'd12);
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        gap++;
        if (done) got = 1;
      end
      if (!got) timeout("b2b");
`ifdef MULT_EARLY_TERM_EN
      check("t5_interval", gap, 4);
`else
      check("t5_interval", gap, 6);
`endif
      check("t5_prod", prod, 8'd12);
    end
    start = 1'b0;

`ifdef MULT_EARLY_TERM_EN
    run_op(4'd7, 4'd0, l, r);
    check("et_y0_latency", l, 2);
    check("et_y0_prod", prod, 8'd0);
    run_op(4'd7, 4'd8, l, r);
    check("et_y8_latency", l, 5);
    check("et_y8_prod", prod, 8'd56);
    check("et_y8_res",  res,  4'd8);
    check("et_y8_ovf",  ovf,  1'b1);
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      x = W'($urandom_range(0, 15));
      y = W'($urandom_range(0, 15));
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
